pipe_seg_buf: RTL and testbench

- Parametrised pipeline segment register with a valid/ready handshake, a generic payload width and a configurable buffer depth.
- Replaces per-stage hand-written segment registers between IF/ID/EX/MEM/WB.
- DEPTH=1 gives the classic single-entry register, where in_ready depends combinationally on out_ready.
- DEPTH>=2 gives a circular skid buffer whose in_ready is a registered function of occupancy, cutting the ready chain between stages.

---
 rtl/pipe_seg_buf.sv | 130 +++++++++++++
 tb/tb_pipe_seg_buf.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_seg_buf.sv
// Pipeline segment buffer with valid/ready handshake between core stages.
// DEPTH=1 is a pass-through register; DEPTH>=2 is a registered-ready skid FIFO.
//
// Parameters:
//   WIDTH  payload bits per entry (>=1)
//   DEPTH  buffer entries (>=1)
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset
//   flush      drop every buffered entry at the next edge
//   ready_go   head entry has finished this stage's work
//   in_valid   upstream entry valid
//   in_ready   entry accepted this cycle
//   in_data    upstream payload
//   out_valid  head entry valid and ready_go
//   out_ready  downstream accepts
//   out_data   head entry payload
//   stall_cnt  head-stall cycle counter (only with PIPE_SEG_STALL_CNT_EN)
// Optional feature macro: PIPE_SEG_STALL_CNT_EN

module pipe_seg_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ready_go,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SEG_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [CW-1:0]    count;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic has;
  logic push;
  logic pop;

  // Wrap explicitly so non-power-of-two depths work;
  // with DEPTH=1 LAST is 0 and the pointer never moves.
  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign has       = (count != '0);
  assign out_valid = has && ready_go;
  assign out_data  = mem[rd_ptr];

  generate
    if (DEPTH == 1) begin : g_reg
      // Single entry: can refill in the cycle it drains.
      assign in_ready = !has
                     || (ready_go && out_ready);
    end else begin : g_skid
      // Registered ready: breaks the ready chain,
      // so a full buffer refuses even on a pop.
      assign in_ready = (count != FULL);
    end
  endgenerate

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          wr_ptr <= inc(wr_ptr);
          count  <= count + CW'(1);
        end
        2'b01: begin
          rd_ptr <= inc(rd_ptr);
          count  <= count - CW'(1);
        end
        2'b11: begin
          wr_ptr <= inc(wr_ptr);
          rd_ptr <= inc(rd_ptr);
        end
        default: begin
          count  <= count;
        end
      endcase
    end
  end

  // Storage is never reset; count alone
  // decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

`ifdef PIPE_SEG_STALL_CNT_EN
  // Counts cycles a held entry did not leave;
  // survives flush, saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (has && !pop
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_seg_buf.sv
// Bench for pipe_seg_buf: DEPTH 1,2,3 side by side,
// compared against a queue model each cycle.

module tb_pipe_seg_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ready_go;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        ir [3];
  logic        ov [3];
  logic [31:0] od [3];
  logic [31:0] sc [3];

  int vectors;
  int miscompares;

  logic [31:0] q [3][$];
  int unsigned sm [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_seg_buf #(
      .WIDTH(32),
      .DEPTH(g + 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .ready_go (ready_go),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .in_data  (in_data),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_data (od[g])
`ifdef PIPE_SEG_STALL_CNT_EN
      ,
      .stall_cnt(sc[g])
`endif
    );
`ifndef PIPE_SEG_STALL_CNT_EN
    assign sc[g] = '0;
`endif
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  // One cycle: drive, check against the model,
  // then advance the model at the clock edge.
  task automatic step(input logic r,
                      input logic f,
                      input logic g,
                      input logic v,
                      input logic o,
                      input logic [31:0] d);
    logic eir [3];
    logic eov [3];
    @(negedge clk);
    rst       = r;
    flush     = f;
    ready_go  = g;
    in_valid  = v;
    out_ready = o;
    in_data   = d;
    #1;
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = q[k].size();
      if (k == 0) eir[k] = (sz == 0) || (g && o);
      else        eir[k] = (sz != k + 1);
      eov[k] = (sz != 0) && g;
      chk($sformatf("in_ready_d%0d", k + 1),
          32'(ir[k]), 32'(eir[k]));
      chk($sformatf("out_valid_d%0d", k + 1),
          32'(ov[k]), 32'(eov[k]));
      if (eov[k])
        chk($sformatf("out_data_d%0d", k + 1),
            od[k], q[k][0]);
`ifdef PIPE_SEG_STALL_CNT_EN
      chk($sformatf("stall_cnt_d%0d", k + 1),
          sc[k], sm[k]);
`endif
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = q[k].size();
      if (r) sm[k] = 0;
      else if (sz != 0 && !(eov[k] && o)
               && sm[k] != 32'hFFFF_FFFF)
        sm[k]++;
      if (r || f) begin
        q[k].delete();
      end else begin
        if (eov[k] && o) void'(q[k].pop_front());
        if (v && eir[k]) q[k].push_back(d);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int k = 0; k < 3; k++) sm[k] = 0;
    rst = 1'b1; flush = 1'b0; ready_go = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);

    // back-to-back stream
    step(0, 0, 1, 1, 1, 32'h11);
    #1 chk("d1_first_out", od[0], 32'h11);
    step(0, 0, 1, 1, 1, 32'h22);
    #1 chk("d1_second_out", od[0], 32'h22);
    step(0, 0, 1, 1, 1, 32'h33);
    #1 chk("d1_third_out", od[0], 32'h33);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);

    // single-entry backpressure
    step(0, 0, 1, 1, 1, 32'hAA);
    step(0, 0, 1, 1, 0, 32'hBB);
    step(0, 0, 1, 1, 0, 32'hBB);
    #1 chk("d1_blocked_ready", 32'(ir[0]), 0);
    chk("d1_held_data", od[0], 32'hAA);
    step(0, 0, 1, 1, 1, 32'hBB);
    #1 chk("d1_swap_data", od[0], 32'hBB);
    repeat (4) step(0, 0, 1, 0, 1, 0);

    // skid fill and drain
    step(0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0, 32'd1);
    step(0, 0, 1, 1, 0, 32'd2);
    step(0, 0, 1, 1, 0, 32'd3);
    #1 chk("d3_full_ready", 32'(ir[2]), 0);
    step(0, 0, 1, 1, 0, 32'd4);
    step(0, 0, 1, 1, 1, 32'd4);
    step(0, 0, 1, 1, 1, 32'd4);
    repeat (5) step(0, 0, 1, 0, 1, 0);

    // flush with traffic present
    step(0, 0, 1, 1, 0, 32'h9);
    step(0, 0, 1, 1, 0, 32'hA);
    step(0, 1, 1, 1, 1, 32'hEE);
    #1 chk("d3_flush_valid", 32'(ov[2]), 0);
    chk("d3_flush_ready", 32'(ir[2]), 1);

    // ready_go hold
    step(0, 0, 1, 1, 0, 32'h5);
    repeat (4) step(0, 0, 0, 0, 1, 0);
    #1 chk("d1_rg_hold", 32'(ov[0]), 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);

    // reset while full
    step(0, 0, 1, 1, 0, 32'h61);
    step(0, 0, 1, 1, 0, 32'h62);
    step(1, 0, 1, 0, 0, 0);
    #1 chk("d2_rst_valid", 32'(ov[1]), 0);
    chk("d2_rst_ready", 32'(ir[1]), 1);
    chk("d2_rst_stall", sc[1], 0);
    step(0, 0, 1, 1, 1, 32'h77);
    #1 chk("d2_after_rst", od[1], 32'h77);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0),
           ($urandom_range(31) == 0),
           ($urandom_range(99) < 85),
           ($urandom_range(99) < 70),
           ($urandom_range(99) < 70),
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
